// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding, load-use bubbles and hold/flush
module id_ex_operand_stage #(
   parameter int CNT_W  = 16,
   parameter bit FWD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_ALUCtrl,
   input  logic             id_Sign,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [31:0]      id_rs_data,
   input  logic [31:0]      id_rt_data,
   input  logic [4:0]       id_rd_dst,
   input  logic [15:0]      id_imm16,
   input  logic [4:0]       id_shamt,
   input  logic             id_ALUSrc1,
   input  logic             id_ALUSrc2,
   input  logic             id_ExtOp,
   input  logic             id_LuOp,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             mem_RegWrite,
   input  logic [4:0]       mem_rd,
   input  logic [31:0]      mem_result,
   input  logic             wb_RegWrite,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   input  logic             hold,
   input  logic             flush,
   output logic             stall_id,
   output logic             ex_valid,
   output logic [4:0]       ex_ALUCtrl,
   output logic             ex_Sign,
   output logic [31:0]      ex_in1,
   output logic [31:0]      ex_in2,
   output logic [31:0]      ex_rt_fwd,
   output logic [4:0]       ex_rd_dst,
   output logic             ex_RegWrite,
   output logic             ex_MemRead,
   output logic [CNT_W-1:0] stall_count
);
   typedef struct packed {
      logic        valid;
      logic [4:0]  alu;
      logic        sign;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic        src1;
      logic        src2;
      logic        rw;
      logic        mr;
   } ex_t;

   ex_t              ex_q, ex_d, id_rec;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      imm_ext, fwd_rs, fwd_rt;
   logic             luse;

   // next-state selection: hold freezes, flush/load-use/empty ID insert a bubble
   always_comb begin
      imm_ext  = id_LuOp ? {id_imm16, 16'h0000} : {{16{id_ExtOp & id_imm16[15]}}, id_imm16};
      id_rec   = {id_valid, id_ALUCtrl, id_Sign, id_rs, id_rt, id_rs_data, id_rt_data, id_rd_dst,
                  imm_ext, id_shamt, id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_MemRead};
      luse     = id_valid & ex_q.valid & ex_q.mr & (|ex_q.rd) & (ex_q.rd == id_rs | ex_q.rd == id_rt);
      stall_id = hold | (luse & ~flush);
      ex_d     = hold ? ex_q : (flush | luse | ~id_valid) ? '0 : id_rec;
      cnt_d    = (~hold & ~flush & luse & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // operand forwarding: EX/MEM beats MEM/WB, register 0 is never forwarded
   always_comb begin
      fwd_rs = (FWD_EN && |ex_q.rs && mem_RegWrite && mem_rd == ex_q.rs) ? mem_result :
               (FWD_EN && |ex_q.rs && wb_RegWrite && wb_rd == ex_q.rs) ? wb_data : ex_q.rs_data;
      fwd_rt = (FWD_EN && |ex_q.rt && mem_RegWrite && mem_rd == ex_q.rt) ? mem_result :
               (FWD_EN && |ex_q.rt && wb_RegWrite && wb_rd == ex_q.rt) ? wb_data : ex_q.rt_data;
   end

   // pipeline register and saturating bubble counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_ALUCtrl  = ex_q.alu;
   assign ex_Sign     = ex_q.sign;
   assign ex_in1      = ex_q.src1 ? {27'b0, ex_q.shamt} : fwd_rs;
   assign ex_in2      = ex_q.src2 ? ex_q.imm : fwd_rt;
   assign ex_rt_fwd   = fwd_rt;
   assign ex_rd_dst   = ex_q.rd;
   assign ex_RegWrite = ex_q.rw;
   assign ex_MemRead  = ex_q.mr;
   assign stall_count = cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage against a reference model
module tb_id_ex_operand_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, id_valid, id_Sign, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp, id_RegWrite, id_MemRead;
   logic [4:0]  id_ALUCtrl, id_rs, id_rt, id_rd_dst, id_shamt, mem_rd, wb_rd;
   logic [31:0] id_rs_data, id_rt_data, mem_result, wb_data;
   logic [15:0] id_imm16;
   logic        mem_RegWrite, wb_RegWrite, hold, flush;

   logic        stall_id, ex_valid, ex_Sign, ex_RegWrite, ex_MemRead;
   logic [4:0]  ex_ALUCtrl, ex_rd_dst;
   logic [31:0] ex_in1, ex_in2, ex_rt_fwd;
   logic [15:0] stall_count;

   logic        s_stall_id, s_ex_valid, s_ex_Sign, s_ex_RegWrite, s_ex_MemRead;
   logic [4:0]  s_ex_ALUCtrl, s_ex_rd_dst;
   logic [31:0] s_ex_in1, s_ex_in2, s_ex_rt_fwd;
   logic [1:0]  s_stall_count;

   id_ex_operand_stage u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUCtrl(id_ALUCtrl), .id_Sign(id_Sign),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rd_dst(id_rd_dst), .id_imm16(id_imm16), .id_shamt(id_shamt), .id_ALUSrc1(id_ALUSrc1),
      .id_ALUSrc2(id_ALUSrc2), .id_ExtOp(id_ExtOp), .id_LuOp(id_LuOp), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data), .hold(hold), .flush(flush),
      .stall_id(stall_id), .ex_valid(ex_valid), .ex_ALUCtrl(ex_ALUCtrl), .ex_Sign(ex_Sign),
      .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_rt_fwd(ex_rt_fwd), .ex_rd_dst(ex_rd_dst),
      .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .stall_count(stall_count)
   );

   id_ex_operand_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUCtrl(id_ALUCtrl), .id_Sign(id_Sign),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rd_dst(id_rd_dst), .id_imm16(id_imm16), .id_shamt(id_shamt), .id_ALUSrc1(id_ALUSrc1),
      .id_ALUSrc2(id_ALUSrc2), .id_ExtOp(id_ExtOp), .id_LuOp(id_LuOp), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data), .hold(hold), .flush(flush),
      .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_ALUCtrl(s_ex_ALUCtrl), .ex_Sign(s_ex_Sign),
      .ex_in1(s_ex_in1), .ex_in2(s_ex_in2), .ex_rt_fwd(s_ex_rt_fwd), .ex_rd_dst(s_ex_rd_dst),
      .ex_RegWrite(s_ex_RegWrite), .ex_MemRead(s_ex_MemRead), .stall_count(s_stall_count)
   );

   typedef struct {
      bit        v, sg, s1, s2, rw, mr;
      bit [4:0]  alu, rs, rt, rd, sh;
      bit [31:0] rsd, rtd, imm;
   } rec_t;

   rec_t m;
   int   bubbles;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] ext_imm();
      if (id_LuOp) return {id_imm16, 16'h0000};
      if (id_ExtOp && id_imm16 >= 16'h8000) return 32'hFFFF0000 + id_imm16;
      return {16'h0000, id_imm16};
   endfunction

   function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] latched);
      if (r == 0) return latched;
      if (mem_RegWrite && mem_rd == r) return mem_result;
      if (wb_RegWrite && wb_rd == r) return wb_data;
      return latched;
   endfunction

   function automatic bit load_use();
      return id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
   endfunction

   task automatic bubble();
      m = '{default: 0};
   endtask

   task automatic model_edge();
      if (hold) return;
      if (flush) bubble();
      else if (load_use()) begin
         bubble();
         bubbles++;
      end else if (!id_valid) bubble();
      else m = '{v: 1, sg: id_Sign, s1: id_ALUSrc1, s2: id_ALUSrc2, rw: id_RegWrite, mr: id_MemRead,
                 alu: id_ALUCtrl, rs: id_rs, rt: id_rt, rd: id_rd_dst, sh: id_shamt,
                 rsd: id_rs_data, rtd: id_rt_data, imm: ext_imm()};
   endtask

   task automatic check_all();
      check("stall_id", stall_id, hold || (load_use() && !flush));
      check("ex_valid", ex_valid, m.v);
      check("ex_ALUCtrl", ex_ALUCtrl, m.alu);
      check("ex_Sign", ex_Sign, m.sg);
      check("ex_in1", ex_in1, m.s1 ? {27'b0, m.sh} : operand(m.rs, m.rsd));
      check("ex_in2", ex_in2, m.s2 ? m.imm : operand(m.rt, m.rtd));
      check("ex_rt_fwd", ex_rt_fwd, operand(m.rt, m.rtd));
      check("ex_rd_dst", ex_rd_dst, m.rd);
      check("ex_RegWrite", ex_RegWrite, m.rw);
      check("ex_MemRead", ex_MemRead, m.mr);
      check("stall_count", stall_count, bubbles > 65535 ? 65535 : bubbles);
      check("stall_count_sat", s_stall_count, bubbles > 3 ? 3 : bubbles);
   endtask

   task automatic cyc();
      #1 check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      {id_valid, id_Sign, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp, id_RegWrite, id_MemRead} = '0;
      {id_ALUCtrl, id_rs, id_rt, id_rd_dst, id_shamt, mem_rd, wb_rd} = '0;
      {id_rs_data, id_rt_data, mem_result, wb_data, id_imm16} = '0;
      {mem_RegWrite, wb_RegWrite, hold, flush} = '0;
   endtask

   task automatic rand_in();
      id_valid     = ($urandom % 4) != 0;
      id_ALUCtrl   = 5'($urandom_range(0, 9));
      id_Sign      = 1'($urandom);
      id_rs        = 5'($urandom % 4);
      id_rt        = 5'($urandom % 4);
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_rd_dst    = 5'($urandom % 4);
      id_imm16     = 16'($urandom);
      id_shamt     = 5'($urandom);
      id_ALUSrc1   = ($urandom % 4) == 0;
      id_ALUSrc2   = 1'($urandom);
      id_ExtOp     = 1'($urandom);
      id_LuOp      = ($urandom % 4) == 0;
      id_RegWrite  = 1'($urandom);
      id_MemRead   = 1'($urandom);
      mem_RegWrite = 1'($urandom);
      mem_rd       = 5'($urandom % 4);
      mem_result   = $urandom;
      wb_RegWrite  = 1'($urandom);
      wb_rd        = 5'($urandom % 4);
      wb_data      = $urandom;
      hold         = ($urandom % 8) == 0;
      flush        = ($urandom % 8) == 0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      bubble();
      bubbles = 0;
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;

      // forwarding priority and register 0
      id_valid = 1; id_rs = 5; id_rs_data = 32'h11;
      cyc();
      id_valid = 0;
      mem_RegWrite = 1; mem_rd = 5; mem_result = 32'h1234;
      wb_RegWrite = 1; wb_rd = 5; wb_data = 32'h9999;
      #1 check("fwd_mem", ex_in1, 32'h1234);
      mem_RegWrite = 0;
      #1 check("fwd_wb", ex_in1, 32'h9999);
      cyc();
      id_valid = 1; id_rs = 0; id_rs_data = 0;
      mem_RegWrite = 1; mem_rd = 0; wb_rd = 0;
      cyc();
      #1 check("fwd_r0", ex_in1, 32'h0);

      // immediate extension and shamt select
      idle();
      id_valid = 1; id_imm16 = 16'hFFFC; id_ALUSrc2 = 1; id_ExtOp = 1;
      cyc();
      #1 check("imm_sext", ex_in2, 32'hFFFFFFFC);
      id_ExtOp = 0;
      cyc();
      #1 check("imm_zext", ex_in2, 32'h0000FFFC);
      id_LuOp = 1;
      cyc();
      #1 check("imm_lui", ex_in2, 32'hFFFC0000);
      id_ALUSrc1 = 1; id_shamt = 3;
      cyc();
      #1 check("shamt", ex_in1, 32'h3);

      // load-use bubble then WB forwarding
      idle();
      id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd_dst = 8;
      cyc();
      idle();
      id_valid = 1; id_rs = 8; id_rd_dst = 9; id_RegWrite = 1;
      #1 check("luse_stall", stall_id, 1'b1);
      cyc();
      #1 check("luse_bubble", ex_valid, 1'b0);
      check("luse_count", stall_count, 16'd1);
      cyc();
      id_valid = 0;
      wb_RegWrite = 1; wb_rd = 8; wb_data = 32'hCAFE;
      #1 check("luse_wb_fwd", ex_in1, 32'hCAFE);
      cyc();

      // hold dominates flush, flush suppresses load-use stall
      idle();
      id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd_dst = 8; id_ALUCtrl = 5'd3;
      cyc();
      idle();
      id_valid = 1; id_rs = 8; hold = 1; flush = 1;
      #1 check("hold_stall", stall_id, 1'b1);
      cyc();
      cyc();
      #1 check("hold_valid", ex_valid, 1'b1);
      check("hold_alu", ex_ALUCtrl, 32'd3);
      hold = 0;
      #1 check("flush_nostall", stall_id, 1'b0);
      cyc();
      #1 check("flush_bubble", ex_valid, 1'b0);

      // back-to-back dependent loads give five bubbles; narrow counter saturates
      idle();
      for (int i = 0; i < 10; i++) begin
         id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd_dst = 8; id_rs = 8;
         cyc();
      end
      #1 check("sat_count", s_stall_count, 2'd3);

      for (int i = 0; i < 3000; i++) begin
         rand_in();
         cyc();
      end

      // asynchronous reset between edges with a live instruction in EX
      idle();
      id_valid = 1; id_rs = 5; id_rs_data = 32'h55; id_RegWrite = 1; id_MemRead = 1; id_rd_dst = 7;
      cyc();
      #1 check("pre_reset_valid", ex_valid, 1'b1);
      idle();
      reset = 1'b1;
      bubble();
      bubbles = 0;
      #1 check("rst_valid", ex_valid, 1'b0);
      check("rst_count", stall_count, 16'd0);
      check("rst_in1", ex_in1, 32'h0);
      check("rst_stall", stall_id, 1'b0);
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 300; i++) begin
         rand_in();
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
